ahb_lite_sram_ctrl_p: RTL and testbench

Parametrised AHB-Lite slave that fronts an on-chip SRAM, replacing the fixed 32-bit/256-word memory controller. It adds byte/halfword/word writes via HSIZE, a correct address/data-phase pipeline, programmable read wait states, write-to-read forwarding and two-cycle ERROR responses for illegal accesses. It sits on the AHB-Lite interconnect as a memory slave, selected by the decoder through HSEL.

---
 rtl/ahb_lite_pkg.sv | 56 +++++
 rtl/ahb_lite_sram_bank.sv | 54 +++++
 rtl/ahb_lite_sram_ctrl_p.sv | 166 ++++++++++++++++
 tb/tb_ahb_lite_sram_ctrl_p.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, controller state type and lane-strobe helpers
// for the SRAM slave.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } ctrl_state_e;

  // Byte-lane strobes for up to 8 lanes; callers truncate to their lane count.
  function automatic logic [7:0] gen_strobe(input logic [2:0] size, input logic [2:0] addr_lo);
    logic [7:0] base;
    case (size)
      HSIZE_BYTE:  base = 8'h01;
      HSIZE_HALF:  base = 8'h03;
      HSIZE_WORD:  base = 8'h0F;
      HSIZE_DWORD: base = 8'hFF;
      default:     base = 8'h00;
    endcase
    return base << addr_lo;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] addr_lo);
    logic mis;
    case (size)
      HSIZE_BYTE:  mis = 1'b0;
      HSIZE_HALF:  mis = addr_lo[0];
      HSIZE_WORD:  mis = |addr_lo[1:0];
      HSIZE_DWORD: mis = |addr_lo;
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_bank.sv
// DEPTH x DATA_W SRAM bank: byte-enable synchronous write port and a
// synchronous read port whose output register holds between reads.
module ahb_lite_sram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int NB    = DATA_W / 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [NB-1:0]     wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // A same-edge write is not visible here; the controller forwards it.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb_lite_sram_ctrl_p.sv
// AHB-Lite SRAM slave: address/data-phase pipeline, sized writes, read wait
// states, write-to-read forwarding and two-cycle ERROR responses.
module ahb_lite_sram_ctrl_p
  import ahb_lite_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int NB     = DATA_W / 8;
  localparam int BYTE_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);

  ctrl_state_e       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic              wr_pend_q, wr_pend_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [NB-1:0]     wr_strb_q, wr_strb_d;
  logic [NB-1:0]     fwd_strb_q, fwd_strb_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic              accept_s, ready_state_s, take_s, illegal_s;
  logic              rd_take_s, wr_take_s, commit_s, fwd_hit_s;
  logic [2:0]        addr_lo_s;
  logic [IDX_W-1:0]  idx_s;
  logic [NB-1:0]     strb_s;
  logic [DATA_W-1:0] bank_rdata_s;
  logic [DATA_W-1:0] hrdata_s;

  assign accept_s  = HSEL & HREADY &
                     ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign addr_lo_s = 3'(HADDR[BYTE_W-1:0]);
  assign idx_s     = HADDR[BYTE_W +: IDX_W];
  assign strb_s    = NB'(gen_strobe(HSIZE, addr_lo_s));
  // Any address bit above the SRAM range makes the access illegal.
  assign illegal_s = ((HADDR >> (BYTE_W + IDX_W)) != '0) |
                     (HSIZE > 3'(BYTE_W)) |
                     is_misaligned(HSIZE, addr_lo_s);

  assign ready_state_s = (state_q == ST_IDLE) | (state_q == ST_ERR2) |
                         ((state_q == ST_RWAIT) & (cnt_q == 3'd0));
  assign take_s    = accept_s & ready_state_s;
  assign rd_take_s = take_s & ~illegal_s & ~HWRITE;
  assign wr_take_s = take_s & ~illegal_s & HWRITE;
  assign commit_s  = wr_pend_q & HREADY;
  assign fwd_hit_s = rd_take_s & commit_s & (wr_idx_q == idx_s);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (!ready_state_s) begin
      cnt_d = cnt_q - 3'd1;
    end else if (take_s && illegal_s) begin
      state_d = ST_ERR1;
    end else if (rd_take_s && (WAIT_STATES != 0)) begin
      state_d = ST_RWAIT;
      cnt_d   = 3'(WAIT_STATES);
    end else begin
      state_d = ST_IDLE;
    end
    hreadyout_d = !((state_d == ST_ERR1) || ((state_d == ST_RWAIT) && (cnt_d != 3'd0)));
    if ((state_d == ST_ERR1) || (state_d == ST_ERR2)) begin
      hresp_d = HRESP_ERROR;
    end else begin
      hresp_d = HRESP_OKAY;
    end
  end

  always_comb begin
    wr_pend_d  = wr_pend_q;
    wr_idx_d   = wr_idx_q;
    wr_strb_d  = wr_strb_q;
    fwd_strb_d = fwd_strb_q;
    fwd_data_d = fwd_data_q;
    if (wr_take_s) begin
      wr_pend_d = 1'b1;
      wr_idx_d  = idx_s;
      wr_strb_d = strb_s;
    end else if (commit_s) begin
      wr_pend_d = 1'b0;
    end else begin
      wr_pend_d = wr_pend_q;
    end
    // Lanes of a same-word write still in its data phase override SRAM data.
    if (rd_take_s) begin
      fwd_strb_d = fwd_hit_s ? wr_strb_q : '0;
      fwd_data_d = HWDATA;
    end else begin
      fwd_strb_d = fwd_strb_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_idx_q    <= '0;
      wr_strb_q   <= '0;
      fwd_strb_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      wr_pend_q   <= wr_pend_d;
      wr_idx_q    <= wr_idx_d;
      wr_strb_q   <= wr_strb_d;
      fwd_strb_q  <= fwd_strb_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  ahb_lite_sram_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .we      (commit_s),
    .waddr   (wr_idx_q),
    .wbe     (wr_strb_q),
    .wdata   (HWDATA),
    .re      (rd_take_s),
    .raddr   (idx_s),
    .rdata   (bank_rdata_s)
  );

  always_comb begin
    hrdata_s = bank_rdata_s;
    for (int b = 0; b < NB; b++) begin
      if (fwd_strb_q[b]) begin
        hrdata_s[8*b +: 8] = fwd_data_q[8*b +: 8];
      end else begin
        hrdata_s[8*b +: 8] = bank_rdata_s[8*b +: 8];
      end
    end
  end

  assign HRDATA    = hrdata_s;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_lite_sram_ctrl_p.sv
// Directed bench for ahb_lite_sram_ctrl_p: three instances (32-bit no wait,
// 32-bit three wait states, 64-bit) sharing one address/data bus.
module tb_ahb_lite_sram_ctrl_p;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [2:0]  hsel;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [63:0] HWDATA;
  logic [31:0] rd0, rd1;
  logic [63:0] rd2;
  logic        rdy0, rdy1, rdy2;
  logic        resp0, resp1, resp2;

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_ctrl_p #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .WAIT_STATES(0)) u_dut_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA[31:0]), .HREADY(rdy0),
    .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0));

  ahb_lite_sram_ctrl_p #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .WAIT_STATES(3)) u_dut_ws3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA[31:0]), .HREADY(rdy1),
    .HRDATA(rd1), .HREADYOUT(rdy1), .HRESP(resp1));

  ahb_lite_sram_ctrl_p #(.DATA_W(64), .DEPTH(1024), .ADDR_W(32), .WAIT_STATES(0)) u_dut_w64 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(rdy2),
    .HRDATA(rd2), .HREADYOUT(rdy2), .HRESP(resp2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input int inst, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [1:0] tr);
    hsel       = 3'b000;
    hsel[inst] = 1'b1;
    HADDR      = a;
    HWRITE     = w;
    HSIZE      = sz;
    HTRANS     = tr;
  endtask

  task automatic idle_bus();
    hsel   = 3'b000;
    HTRANS = T_IDLE;
    HWRITE = 1'b0;
  endtask

  function automatic logic rdy_of(input int inst);
    if (inst == 0) return rdy0;
    else if (inst == 1) return rdy1;
    else return rdy2;
  endfunction

  task automatic single_write(input int inst, input logic [31:0] a, input logic [2:0] sz,
                              input logic [63:0] data);
    drive(inst, a, 1'b1, sz, T_NSEQ);
    tick();
    HWDATA = data;
    idle_bus();
    tick();
  endtask

  // Returns the number of data-phase cycles with HREADYOUT low (bounded).
  task automatic single_read(input int inst, input logic [31:0] a, input logic [2:0] sz,
                             output int waits);
    drive(inst, a, 1'b0, sz, T_NSEQ);
    tick();
    idle_bus();
    waits = 0;
    while (!rdy_of(inst) && waits < 20) begin
      waits++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0;
    hsel    = 3'b000;
    HADDR   = 32'h0;
    HTRANS  = T_IDLE;
    HWRITE  = 1'b0;
    HSIZE   = 3'd0;
    HWDATA  = 64'h0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_ready", {63'd0, rdy0}, 64'd1);
    chk("rst_resp", {63'd0, resp0}, 64'd0);
    chk("rst_rdata", {32'd0, rd0}, 64'd0);
    chk("rst_rdata64", rd2, 64'd0);
    HRESETn = 1'b1;
    tick();

    // Word then halfword write, then plain read
    single_write(0, 32'h10, 3'd2, 64'hDEADBEEF);
    single_write(0, 32'h12, 3'd1, 64'h12340000);
    single_read(0, 32'h10, 3'd2, n);
    chk("hw_wait", 64'(n), 64'd0);
    chk("hw_data", {32'd0, rd0}, 64'h1234BEEF);
    chk("hw_resp", {63'd0, resp0}, 64'd0);

    // Three read wait states
    single_write(1, 32'h10, 3'd2, 64'hCAFEF00D);
    single_read(1, 32'h10, 3'd2, n);
    chk("ws3_wait", 64'(n), 64'd3);
    chk("ws3_data", {32'd0, rd1}, 64'hCAFEF00D);
    chk("ws3_resp", {63'd0, resp1}, 64'd0);

    // Byte write forwarded into a back-to-back read of the same word
    single_write(0, 32'h20, 3'd2, 64'h11223344);
    drive(0, 32'h21, 1'b1, 3'd0, T_NSEQ);
    tick();
    HWDATA = 64'h5555AA55;
    drive(0, 32'h20, 1'b0, 3'd2, T_NSEQ);
    tick();
    idle_bus();
    HWDATA = 64'h0;
    chk("fwd_ready", {63'd0, rdy0}, 64'd1);
    chk("fwd_data", {32'd0, rd0}, 64'h1122AA44);
    single_read(0, 32'h20, 3'd2, n);
    chk("fwd_mem", {32'd0, rd0}, 64'h1122AA44);

    // Out-of-range read, then follow-ups issued in ERR2
    drive(0, 32'h1000, 1'b0, 3'd2, T_NSEQ);
    tick();
    idle_bus();
    chk("oor_err1_rdy", {63'd0, rdy0}, 64'd0);
    chk("oor_err1_resp", {63'd0, resp0}, 64'd1);
    chk("oor_hold", {32'd0, rd0}, 64'h1122AA44);
    tick();
    chk("oor_err2_rdy", {63'd0, rdy0}, 64'd1);
    chk("oor_err2_resp", {63'd0, resp0}, 64'd1);
    drive(0, 32'h1010, 1'b1, 3'd2, T_NSEQ);
    tick();
    HWDATA = 64'hFFFFFFFF;
    idle_bus();
    chk("oorw_err1_rdy", {63'd0, rdy0}, 64'd0);
    chk("oorw_err1_resp", {63'd0, resp0}, 64'd1);
    tick();
    chk("oorw_err2_resp", {63'd0, resp0}, 64'd1);
    drive(0, 32'h12, 1'b1, 3'd2, T_NSEQ);
    tick();
    HWDATA = 64'hFFFFFFFF;
    idle_bus();
    chk("mis_err1_rdy", {63'd0, rdy0}, 64'd0);
    chk("mis_err1_resp", {63'd0, resp0}, 64'd1);
    tick();
    chk("mis_err2_rdy", {63'd0, rdy0}, 64'd1);
    chk("mis_err2_resp", {63'd0, resp0}, 64'd1);
    drive(0, 32'h10, 1'b0, 3'd2, T_NSEQ);
    tick();
    idle_bus();
    chk("err2_next_rdy", {63'd0, rdy0}, 64'd1);
    chk("err2_next_resp", {63'd0, resp0}, 64'd0);
    chk("err_nochange", {32'd0, rd0}, 64'h1234BEEF);

    // BUSY with HSEL high does nothing
    drive(0, 32'h10, 1'b1, 3'd2, T_BUSY);
    tick();
    HWDATA = 64'hFFFFFFFF;
    idle_bus();
    chk("busy_rdy", {63'd0, rdy0}, 64'd1);
    chk("busy_resp", {63'd0, resp0}, 64'd0);
    tick();
    single_read(0, 32'h10, 3'd2, n);
    chk("busy_nowrite", {32'd0, rd0}, 64'h1234BEEF);

    // 64-bit lane 7 byte write
    single_write(2, 32'h0, 3'd3, 64'h8877665544332211);
    single_write(2, 32'h7, 3'd0, 64'h77AAAAAAAAAAAAAA);
    single_read(2, 32'h0, 3'd3, n);
    chk("w64_lane7", rd2, 64'h7777665544332211);

    // Reset during RWAIT
    drive(1, 32'h10, 1'b0, 3'd2, T_NSEQ);
    tick();
    idle_bus();
    chk("rwait_low", {63'd0, rdy1}, 64'd0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rstmid_rdy", {63'd0, rdy1}, 64'd1);
    chk("rstmid_resp", {63'd0, resp1}, 64'd0);
    chk("rstmid_rdata", {32'd0, rd1}, 64'd0);
    #3;
    HRESETn = 1'b1;
    tick();

    // Reset during a write data phase discards the write
    drive(0, 32'h10, 1'b1, 3'd2, T_NSEQ);
    tick();
    HWDATA = 64'h0;
    idle_bus();
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rstwr_rdata", {32'd0, rd0}, 64'd0);
    #3;
    HRESETn = 1'b1;
    tick();
    single_read(0, 32'h10, 3'd2, n);
    chk("rstwr_discard", {32'd0, rd0}, 64'h1234BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
